pll_reset_sequencer: RTL
========================

Name: pll_reset_sequencer

Overview:
- Controls a PLL wrapper from its reference-clock domain.
- Drives the PLL reset input and consumes the PLL's asynchronous locked output.
- Qualifies lock as stable, then releases per-domain downstream resets in a staggered order.
- On loss of lock: re-asserts all downstream resets and re-initialises the PLL. After repeated lock failures it reports a hard fault.

Parameters:
- RST_PULSE_CYCLES, 16: refclk cycles pll_rst is held high per PLL reset attempt.
- LOCK_STABLE_CYCLES, 1024: consecutive synchronised-locked cycles required before releasing resets.
- LOCK_TIMEOUT_CYCLES, 65536: cycles allowed in WAIT_LOCK before a retry.
- MAX_RETRIES, 3: timed-out attempts tolerated; the next timeout enters FAIL.
- NUM_DOMAINS, 2: number of downstream reset outputs (one per PLL output clock).
- STAGGER_CYCLES, 8: spacing between successive domain reset releases.

Ports:
- refclk  in  1  PLL reference clock; the only clock of this block.
- rst  in  1  asynchronous, active-high reset.
- locked_in  in  1  PLL locked flag; asynchronous to refclk.
- clear_fail  in  1  single-cycle pulse; restarts the sequence from FAIL.
- pll_rst  out  1  reset to the PLL, active-high.
- dom_rst  out  NUM_DOMAINS  per-domain resets, active-high, registered.
- ready  out  1  high while in RUN.
- fail  out  1  high while in FAIL.
- retry_cnt  out  4  timeouts since the last successful lock.
- lol_cnt  out  8  loss-of-lock events; saturates at 255.

Behaviour:
- Reset values (asynchronous, immediate): pll_rst=1, dom_rst=all 1, ready=0, fail=0, retry_cnt=0, lol_cnt=0, state=PLL_RST, cnt=0.
- Synchronisation:
  - locked_in passes through a 2-flop synchroniser to give locked_s.
  - Latency from locked_in to locked_s is 2 refclk edges.
  - All decisions use locked_s only.
- One shared cycle counter, cnt. It is cleared on every state transition.
- PLL_RST:
  - pll_rst=1, dom_rst all 1.
  - When cnt == RST_PULSE_CYCLES-1: go to WAIT_LOCK; pll_rst=0 from the next cycle.
- WAIT_LOCK:
  - If locked_s=1: go to STABLE.
  - Else if cnt == LOCK_TIMEOUT_CYCLES-1: increment retry_cnt. If the new value > MAX_RETRIES, go to FAIL; otherwise go to PLL_RST.
- STABLE:
  - If locked_s=0: go to WAIT_LOCK. This is not a retry and not a loss-of-lock event.
  - When cnt == LOCK_STABLE_CYCLES-1 with locked_s still 1: go to RELEASE.
- RELEASE:
  - dom_rst[i] deasserts on the cycle cnt == (i+1)*STAGGER_CYCLES-1, for i = 0 first. Once cleared, a bit stays cleared.
  - After dom_rst[NUM_DOMAINS-1] clears: go to RUN, set ready=1, clear retry_cnt.
- RUN: hold until locked_s=0.
- Loss of lock (locked_s=0 in RELEASE or RUN):
  - On the next edge: dom_rst all 1, ready=0, lol_cnt++ (saturating), go to PLL_RST.
  - Total latency from locked_in falling to dom_rst asserted: 3 edges.
- FAIL:
  - pll_rst=1, dom_rst all 1, fail=1.
  - clear_fail=1: retry_cnt=0, fail=0, go to PLL_RST.
  - clear_fail is ignored in all other states.
- Simultaneous events:
  - The WAIT_LOCK timeout and locked_s rising in the same cycle: lock wins and the state goes to STABLE.
  - Loss of lock on the exact cycle the last domain would release: loss wins and dom_rst stays all 1.
- No combinational path from any input to any output. Every output is a flop.

Decomposition:
- Package pll_rst_seq_pkg:
  - State enum: PLL_RST, WAIT_LOCK, STABLE, RELEASE, RUN, FAIL.
  - CNT_W = clog2 of the max of (LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES, NUM_DOMAINS*STAGGER_CYCLES).
  - Width constants for retry_cnt (4) and lol_cnt (8).
- Sub-module: sync_2ff. A generic 2-flop synchroniser with async reset to 0, instantiated for locked_in.

Test Plan:
Test parameters: RST_PULSE=4, STABLE=8, TIMEOUT=32, MAX_RETRIES=2, STAGGER=3, NUM_DOMAINS=2.
- Clean start: rst released, locked_in rises 10 cycles later -> pll_rst low after 4 cycles. dom_rst[0] clears 3 cycles after STABLE completes, dom_rst[1] 6 cycles after. ready=1, retry_cnt=0.
- Glitchy lock: locked_in high 5 cycles, low 1, then steady -> returns to WAIT_LOCK. lol_cnt stays 0, retry_cnt stays 0. Release occurs 8 stable cycles after the steady high.
- Timeouts to FAIL: locked_in held 0 -> three PLL_RST pulses; the third 32-cycle timeout gives fail=1, retry_cnt=3, pll_rst held 1. clear_fail pulse -> fail=0, retry_cnt=0, a new 4-cycle pll_rst pulse.
- Loss of lock in RUN: drop locked_in -> dom_rst=2'b11 and ready=0 on the 3rd edge, lol_cnt=1, pll_rst pulse follows. Restore lock -> full re-release.
- Loss during RELEASE: drop locked_in after dom_rst[0] clears -> dom_rst=2'b11, lol_cnt increments, state goes to PLL_RST.
- Async reset mid-RUN: assert rst -> all outputs at reset values without waiting for a clock edge. lol_cnt returns to 0.

Source files
------------

// File: rtl/pll_rst_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer.
//   state_t   : sequencer states
//   RETRY_W   : width of the retry counter output
//   LOL_W     : width of the loss-of-lock counter output
//   cnt_width : width of the shared phase counter for a given parameter set
//   CNT_W     : counter width for the default parameter set
package pll_rst_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4,
    FAIL      = 3'd5
  } state_t;

  localparam int RETRY_W = 4;
  localparam int LOL_W   = 8;

  // Wide enough to hold (longest phase length - 1).
  function automatic int cnt_width(input int timeout_c, input int stable_c, input int release_c);
    int m;
    m = timeout_c;
    if (stable_c > m) m = stable_c;
    if (release_c > m) m = release_c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  localparam int CNT_W = cnt_width(65536, 1024, 2 * 8);

endpackage

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Generic two-flop synchroniser, async reset to 0.
//   clk : destination clock
//   rst : asynchronous active-high reset
//   d   : asynchronous input
//   q   : synchronised output (2 clk edges of latency)
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset / lock-qualification sequencer, clocked by the PLL reference clock.
// Pulses the PLL reset, waits for lock, qualifies it as stable, then releases
// downstream domain resets one at a time. Loss of lock restarts everything;
// too many lock timeouts park the block in FAIL until clear_fail.
//   refclk     : reference clock (only clock)
//   rst        : asynchronous active-high reset
//   locked_in  : PLL locked flag, asynchronous
//   clear_fail : pulse, leaves FAIL
//   pll_rst    : PLL reset, active-high
//   dom_rst    : per-domain resets, active-high
//   ready      : high in RUN
//   fail       : high in FAIL
//   retry_cnt  : lock timeouts since last successful lock
//   lol_cnt    : loss-of-lock events, saturating
//
// state     | meaning
// PLL_RST   | holding pll_rst for RST_PULSE_CYCLES
// WAIT_LOCK | waiting for locked_s, bounded by LOCK_TIMEOUT_CYCLES
// STABLE    | lock must hold for LOCK_STABLE_CYCLES
// RELEASE   | domain resets released every STAGGER_CYCLES
// RUN       | all domains out of reset
// FAIL      | retries exhausted, waiting for clear_fail
module pll_reset_sequencer
  import pll_rst_seq_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 3,
  parameter int NUM_DOMAINS         = 2,
  parameter int STAGGER_CYCLES      = 8
) (
  input  logic                   refclk,
  input  logic                   rst,
  input  logic                   locked_in,
  input  logic                   clear_fail,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] dom_rst,
  output logic                   ready,
  output logic                   fail,
  output logic [RETRY_W-1:0]     retry_cnt,
  output logic [LOL_W-1:0]       lol_cnt
);

  localparam int CW = cnt_width(LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES,
                                NUM_DOMAINS * STAGGER_CYCLES);

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic                   locked_s;
  logic                   pll_rst_nxt, ready_nxt, fail_nxt;
  logic [NUM_DOMAINS-1:0] dom_rst_nxt;
  logic [RETRY_W-1:0]     retry_nxt, retry_inc;
  logic [LOL_W-1:0]       lol_nxt, lol_inc;

  sync_2ff u_sync_locked (
    .clk (refclk),
    .rst (rst),
    .d   (locked_in),
    .q   (locked_s)
  );

  assign retry_inc = retry_cnt + 1'b1;
  assign lol_inc   = (lol_cnt == '1) ? lol_cnt : lol_cnt + 1'b1;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + 1'b1;
    dom_rst_nxt = dom_rst;
    retry_nxt   = retry_cnt;
    lol_nxt     = lol_cnt;

    case (state)
      PLL_RST: begin
        if (cnt == CW'(RST_PULSE_CYCLES - 1)) state_nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // Lock takes priority over a coincident timeout.
        if (locked_s) begin
          state_nxt = STABLE;
        end else if (cnt == CW'(LOCK_TIMEOUT_CYCLES - 1)) begin
          retry_nxt = retry_inc;
          state_nxt = (int'(retry_inc) > MAX_RETRIES) ? FAIL : PLL_RST;
        end
      end
      STABLE: begin
        if (!locked_s) state_nxt = WAIT_LOCK;
        else if (cnt == CW'(LOCK_STABLE_CYCLES - 1)) state_nxt = RELEASE;
      end
      RELEASE: begin
        // Loss of lock overrides any release due on the same cycle.
        if (!locked_s) begin
          lol_nxt   = lol_inc;
          state_nxt = PLL_RST;
        end else begin
          for (int i = 0; i < NUM_DOMAINS; i++) begin
            if (cnt == CW'((i + 1) * STAGGER_CYCLES - 1)) dom_rst_nxt[i] = 1'b0;
          end
          if (cnt == CW'(NUM_DOMAINS * STAGGER_CYCLES - 1)) begin
            retry_nxt = '0;
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (!locked_s) begin
          lol_nxt   = lol_inc;
          state_nxt = PLL_RST;
        end
      end
      FAIL: begin
        if (clear_fail) begin
          retry_nxt = '0;
          state_nxt = PLL_RST;
        end
      end
      default: state_nxt = PLL_RST;
    endcase

    if (state_nxt != state) cnt_nxt = '0;
    if (!(state_nxt inside {RELEASE, RUN})) dom_rst_nxt = '1;

    // Outputs are registered from the next state so they change with it.
    pll_rst_nxt = (state_nxt == PLL_RST) || (state_nxt == FAIL);
    ready_nxt   = (state_nxt == RUN);
    fail_nxt    = (state_nxt == FAIL);
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state     <= PLL_RST;
      cnt       <= '0;
      pll_rst   <= 1'b1;
      dom_rst   <= '1;
      ready     <= 1'b0;
      fail      <= 1'b0;
      retry_cnt <= '0;
      lol_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      pll_rst   <= pll_rst_nxt;
      dom_rst   <= dom_rst_nxt;
      ready     <= ready_nxt;
      fail      <= fail_nxt;
      retry_cnt <= retry_nxt;
      lol_cnt   <= lol_nxt;
    end
  end

endmodule
